// File: rtl/tpg_ctrl_if.sv
`default_nettype none
// ============================================================================
// tpg_ctrl_if : shadow-register write/commit port of the tpg timing controller
// Rev 1.0
// ============================================================================
interface tpg_ctrl_if;
  logic        cfg_wr;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_commit;

  modport master (
    output cfg_wr,
    output cfg_addr,
    output cfg_wdata,
    output cfg_commit
  );

  modport slave (
    input cfg_wr,
    input cfg_addr,
    input cfg_wdata,
    input cfg_commit
  );
endinterface
`default_nettype wire

// File: rtl/tpg_ctrl.sv
`default_nettype none
// ============================================================================
// tpg_ctrl : run/stop sequencer and shadow/active raster timing controller
// Rev 1.0
// ============================================================================
module tpg_ctrl #(
  parameter int H_BITS = 12,
  parameter int V_BITS = 12
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  tpg_ctrl_if.slave              cfg,
  input  wire logic              run_req,
  input  wire logic              frame_end,
  output logic [H_BITS-1:0]      tHS_START,
  output logic [H_BITS-1:0]      tHS_END,
  output logic [H_BITS-1:0]      tHACT_START,
  output logic [H_BITS-1:0]      tHACT_END,
  output logic [H_BITS-1:0]      tH_END,
  output logic [V_BITS-1:0]      tVS_START,
  output logic [V_BITS-1:0]      tVS_END,
  output logic [V_BITS-1:0]      tVACT_START,
  output logic [V_BITS-1:0]      tVACT_END,
  output logic [V_BITS-1:0]      tV_END,
  output logic                   tpg_en,
  output logic                   commit_pending,
  output logic                   cfg_err,
  output logic [15:0]            frame_cnt
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;

  logic [H_BITS-1:0] r_shH  [5];
  logic [V_BITS-1:0] r_shV  [5];
  logic [H_BITS-1:0] r_actH [5];
  logic [V_BITS-1:0] r_actV [5];

  logic [1:0]  r_state;
  logic [1:0]  w_stateNxt;
  logic        r_tpgEn;
  logic        r_pending;
  logic        r_err;
  logic [15:0] r_frameCnt;
  logic        w_apply;
  logic        w_startBlocked;
  logic        w_shadowValid;
  logic        w_activeValid;
  logic        w_unusedWdata;

  // Index order in each group: SYNC_START, SYNC_END, ACT_START, ACT_END, END.
  function automatic logic fnGroupOk(input logic [31:0] syncS, input logic [31:0] syncE,
                                     input logic [31:0] actS, input logic [31:0] actE,
                                     input logic [31:0] lim);
    return (syncS < syncE) && (syncE <= lim) && (actS < actE) && (actE <= lim);
  endfunction

  assign w_shadowValid =
      fnGroupOk(32'(r_shH[0]), 32'(r_shH[1]), 32'(r_shH[2]), 32'(r_shH[3]), 32'(r_shH[4])) &&
      fnGroupOk(32'(r_shV[0]), 32'(r_shV[1]), 32'(r_shV[2]), 32'(r_shV[3]), 32'(r_shV[4]));
  assign w_activeValid =
      fnGroupOk(32'(r_actH[0]), 32'(r_actH[1]), 32'(r_actH[2]), 32'(r_actH[3]), 32'(r_actH[4])) &&
      fnGroupOk(32'(r_actV[0]), 32'(r_actV[1]), 32'(r_actV[2]), 32'(r_actV[3]), 32'(r_actV[4]));

  assign w_unusedWdata = ^cfg.cfg_wdata;

  // While running, the active set may only change on a frame boundary.
  assign w_apply = r_pending && ((r_state == IDLE) || frame_end);

  always_comb begin
    w_stateNxt     = r_state;
    w_startBlocked = 1'b0;
    case (r_state)
      IDLE: begin
        if (run_req) begin
          if (w_activeValid) w_stateNxt = RUN;
          else               w_startBlocked = 1'b1;
        end
      end
      RUN: begin
        if (!run_req) w_stateNxt = STOPPING;
      end
      STOPPING: begin
        if (frame_end)    w_stateNxt = IDLE;
        else if (run_req) w_stateNxt = RUN;
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        r_shH[i]  <= '0;
        r_shV[i]  <= '0;
        r_actH[i] <= '0;
        r_actV[i] <= '0;
      end
    end else begin
      // Active capture sees the shadow as it stood before this edge.
      if (w_apply && w_shadowValid) begin
        r_actH <= r_shH;
        r_actV <= r_shV;
      end
      for (int i = 0; i < 5; i++) begin
        if (cfg.cfg_wr && (cfg.cfg_addr == 4'(i)))     r_shH[i] <= cfg.cfg_wdata[H_BITS-1:0];
        if (cfg.cfg_wr && (cfg.cfg_addr == 4'(i + 5))) r_shV[i] <= cfg.cfg_wdata[V_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tpgEn    <= 1'b0;
      r_pending  <= 1'b0;
      r_err      <= 1'b0;
      r_frameCnt <= '0;
    end else begin
      r_state <= w_stateNxt;
      r_tpgEn <= (w_stateNxt != IDLE);

      if (w_apply)         r_pending <= 1'b0;
      else if (cfg.cfg_commit) r_pending <= 1'b1;

      // A commit outcome landing on the same edge overrides a blocked start.
      if (w_apply)             r_err <= !w_shadowValid;
      else if (w_startBlocked) r_err <= 1'b1;

      if (frame_end && r_tpgEn) r_frameCnt <= r_frameCnt + 16'd1;
    end
  end

  assign tHS_START      = r_actH[0];
  assign tHS_END        = r_actH[1];
  assign tHACT_START    = r_actH[2];
  assign tHACT_END      = r_actH[3];
  assign tH_END         = r_actH[4];
  assign tVS_START      = r_actV[0];
  assign tVS_END        = r_actV[1];
  assign tVACT_START    = r_actV[2];
  assign tVACT_END      = r_actV[3];
  assign tV_END         = r_actV[4];
  assign tpg_en         = r_tpgEn;
  assign commit_pending = r_pending;
  assign cfg_err        = r_err;
  assign frame_cnt      = r_frameCnt;

endmodule
`default_nettype wire

// File: tb/tb_tpg_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tpg_ctrl : directed and randomized bench for tpg_ctrl with a reference model
// Rev 1.0
// ============================================================================
module tb_tpg_ctrl;
  localparam int H_BITS = 12;
  localparam int V_BITS = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run_req = 1'b0;
  logic frame_end = 1'b0;

  logic [H_BITS-1:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
  logic [V_BITS-1:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
  logic              tpg_en, commit_pending, cfg_err;
  logic [15:0]       frame_cnt;

  tpg_ctrl_if cfgIf ();

  tpg_ctrl #(.H_BITS(H_BITS), .V_BITS(V_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfgIf), .run_req(run_req), .frame_end(frame_end),
    .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
    .tHACT_END(tHACT_END), .tH_END(tH_END), .tVS_START(tVS_START), .tVS_END(tVS_END),
    .tVACT_START(tVACT_START), .tVACT_END(tVACT_END), .tV_END(tV_END),
    .tpg_en(tpg_en), .commit_pending(commit_pending), .cfg_err(cfg_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register file contents and controller status as plain values.
  int mSh [10];
  int mAct[10];
  bit mPend, mErr, mEn, mStop;
  int mCnt;

  function automatic bit cfgValid(input int v[10]);
    return (v[0] < v[1]) && (v[1] <= v[4]) && (v[2] < v[3]) && (v[3] <= v[4]) &&
           (v[5] < v[6]) && (v[6] <= v[9]) && (v[7] < v[8]) && (v[8] <= v[9]);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 10; i++) begin
      mSh[i]  = 0;
      mAct[i] = 0;
    end
    mPend = 0; mErr = 0; mEn = 0; mStop = 0; mCnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs held before that edge.
  task automatic modelStep();
    bit apply, shValid, actValid;
    int a, bits;
    shValid  = cfgValid(mSh);
    actValid = cfgValid(mAct);
    apply    = mPend && (!mEn || frame_end);
    if (frame_end && mEn) mCnt = (mCnt + 1) % 65536;
    if (!mEn) begin
      if (run_req) begin
        if (actValid) begin mEn = 1; mStop = 0; end
        else mErr = 1;
      end
    end else if (!mStop) begin
      if (!run_req) mStop = 1;
    end else if (frame_end) begin
      mEn = 0; mStop = 0;
    end else if (run_req) begin
      mStop = 0;
    end
    if (apply) begin
      if (shValid) begin
        mAct = mSh;
        mErr = 0;
      end else begin
        mErr = 1;
      end
      mPend = 0;
    end else if (cfgIf.cfg_commit) begin
      mPend = 1;
    end
    if (cfgIf.cfg_wr && (int'(cfgIf.cfg_addr) < 10)) begin
      a    = int'(cfgIf.cfg_addr);
      bits = (a < 5) ? H_BITS : V_BITS;
      mSh[a] = int'(cfgIf.cfg_wdata) & ((1 << bits) - 1);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic [31:0] obs[10];
    obs[0] = 32'(tHS_START);   obs[1] = 32'(tHS_END);   obs[2] = 32'(tHACT_START);
    obs[3] = 32'(tHACT_END);   obs[4] = 32'(tH_END);    obs[5] = 32'(tVS_START);
    obs[6] = 32'(tVS_END);     obs[7] = 32'(tVACT_START); obs[8] = 32'(tVACT_END);
    obs[9] = 32'(tV_END);
    for (int i = 0; i < 10; i++) chk($sformatf("active[%0d]", i), obs[i], 32'(mAct[i]));
    chk("tpg_en", 32'(tpg_en), 32'(mEn));
    chk("commit_pending", 32'(commit_pending), 32'(mPend));
    chk("cfg_err", 32'(cfg_err), 32'(mErr));
    chk("frame_cnt", 32'(frame_cnt), 32'(mCnt));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) modelReset();
    else        modelStep();
    #1;
    checkAll();
  endtask

  task automatic doReset();
    rst_n = 1'b0; run_req = 1'b0; frame_end = 1'b0;
    cfgIf.cfg_wr = 1'b0; cfgIf.cfg_addr = 4'd0; cfgIf.cfg_wdata = 16'd0; cfgIf.cfg_commit = 1'b0;
    #1;
    modelReset();
    checkAll();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic writeReg(input int addr, input int data);
    cfgIf.cfg_wr = 1'b1; cfgIf.cfg_addr = 4'(addr); cfgIf.cfg_wdata = 16'(data);
    cycle();
    cfgIf.cfg_wr = 1'b0;
  endtask

  task automatic writeCfg(input int v[10]);
    for (int i = 0; i < 10; i++) writeReg(i, v[i]);
  endtask

  task automatic commit();
    cfgIf.cfg_commit = 1'b1;
    cycle();
    cfgIf.cfg_commit = 1'b0;
  endtask

  task automatic pulseFrameEnd();
    frame_end = 1'b1;
    cycle();
    frame_end = 1'b0;
  endtask

  task automatic randomCfg(output int v[10]);
    int hEnd, vEnd, e;
    hEnd = int'($urandom_range(2, 4095));
    vEnd = int'($urandom_range(2, 4095));
    v[4] = hEnd;
    v[9] = vEnd;
    for (int p = 0; p < 4; p++) begin
      int lim, base;
      lim  = (p < 2) ? hEnd : vEnd;
      base = (p < 2) ? 2 * p : 5 + 2 * (p - 2);
      e = int'($urandom_range(1, lim));
      v[base + 1] = e;
      v[base]     = int'($urandom_range(0, e - 1));
    end
    if ($urandom_range(0, 3) == 0) v[$urandom_range(0, 9)] = int'($urandom_range(0, 65535));
  endtask

  initial begin
    int cfgA[10];
    int rc[10];
    cfgA = '{10, 20, 30, 100, 110, 2, 4, 6, 50, 55};

    // Configuration straight out of reset
    doReset();
    writeCfg(cfgA);
    commit();
    cycle();
    chk("t1_tH_END", 32'(tH_END), 32'd110);
    chk("t1_tVS_END", 32'(tVS_END), 32'd4);
    chk("t1_cfg_err", 32'(cfg_err), 32'd0);

    // Start refused with reset (invalid) active set, then released by a valid commit
    doReset();
    run_req = 1'b1;
    repeat (3) cycle();
    chk("t2_blocked_en", 32'(tpg_en), 32'd0);
    chk("t2_blocked_err", 32'(cfg_err), 32'd1);
    writeCfg(cfgA);
    commit();
    cycle();
    chk("t2_en_at_apply", 32'(tpg_en), 32'd0);
    cycle();
    chk("t2_en_after_apply", 32'(tpg_en), 32'd1);

    // Invalid commit while running
    writeReg(1, 5);
    commit();
    repeat (3) cycle();
    chk("t3_hold_tHS_END", 32'(tHS_END), 32'd20);
    pulseFrameEnd();
    chk("t3_err", 32'(cfg_err), 32'd1);
    chk("t3_pending", 32'(commit_pending), 32'd0);
    chk("t3_tHS_END", 32'(tHS_END), 32'd20);

    // Deferred commit, including commit coincident with frame_end
    writeReg(1, 20);
    writeReg(4, 120);
    commit();
    cycle();
    cycle();
    chk("t4_old_tH_END", 32'(tH_END), 32'd110);
    pulseFrameEnd();
    chk("t4_new_tH_END", 32'(tH_END), 32'd120);
    chk("t4_err_clear", 32'(cfg_err), 32'd0);
    writeReg(4, 130);
    cfgIf.cfg_commit = 1'b1;
    frame_end = 1'b1;
    cycle();
    cfgIf.cfg_commit = 1'b0;
    frame_end = 1'b0;
    chk("t4_same_cycle_hold", 32'(tH_END), 32'd120);
    chk("t4_same_cycle_pend", 32'(commit_pending), 32'd1);
    cycle();
    pulseFrameEnd();
    chk("t4_next_frame", 32'(tH_END), 32'd130);

    // Stop on frame boundary, and restart before the boundary
    run_req = 1'b0;
    repeat (3) cycle();
    chk("t5_stopping_en", 32'(tpg_en), 32'd1);
    pulseFrameEnd();
    chk("t5_stopped_en", 32'(tpg_en), 32'd0);
    run_req = 1'b1;
    cycle();
    chk("t5_restart_en", 32'(tpg_en), 32'd1);
    run_req = 1'b0;
    repeat (2) cycle();
    run_req = 1'b1;
    repeat (3) cycle();
    pulseFrameEnd();
    chk("t5_no_gap_en", 32'(tpg_en), 32'd1);

    // Frame counter wrap
    frame_end = 1'b1;
    for (int n = 0; n < 70000 && mCnt != 65535; n++) cycle();
    chk("t6_cnt_at_max", 32'(frame_cnt), 32'd65535);
    cycle();
    frame_end = 1'b0;
    chk("t6_cnt_wrap", 32'(frame_cnt), 32'd0);

    // Asynchronous reset mid-frame
    repeat (2) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    chk("t6_async_en", 32'(tpg_en), 32'd0);
    chk("t6_async_tH_END", 32'(tH_END), 32'd0);
    checkAll();
    cycle();
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        randomCfg(rc);
        frame_end = 1'b0;
        writeCfg(rc);
      end
      cfgIf.cfg_wr     = ($urandom_range(0, 7) == 0);
      cfgIf.cfg_addr   = 4'($urandom_range(0, 15));
      cfgIf.cfg_wdata  = 16'($urandom);
      cfgIf.cfg_commit = ($urandom_range(0, 15) == 0);
      frame_end        = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) run_req = ~run_req;
      cycle();
    end
    cfgIf.cfg_wr = 1'b0;
    cfgIf.cfg_commit = 1'b0;
    frame_end = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
